// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input_debouncer block: per-channel FSM state
// encodings, the board-default stability window and a clog2 helper used to
// size the stability counter.
package input_debouncer_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_e;

  // 20 ms at 50 MHz.
  localparam int DB_STABLE_50MHZ_20MS = 32'd1000000;

  // Ceiling log2; returns the number of bits needed to count 0..value-1.
  function automatic int db_clog2(input int value);
    int result;
    int v;
    result = 32'd0;
    v = value - 32'd1;
    while (v > 32'd0) begin
      result = result + 32'd1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/input_debouncer_channel.sv
// One debounced input bit: 2-flop synchronizer, stability counter and the
// two-state debounce FSM. Optional edge-pulse registers are built when the
// DEBOUNCE_EDGE_EN macro is defined.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_STABLE_50MHZ_20MS
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic clean_out
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise_pulse,
  output logic fall_pulse
`endif
);

  // Counter only ever reaches STABLE_CYCLES, so this width never wraps.
  localparam int CNT_W = db_clog2(STABLE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  db_state_e        state;
  db_state_e        state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             clean_next;

  // Two-flop synchronizer; only sync2 is used past this point.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Next-state logic: count consecutive cycles that sync2 differs from the
  // current clean level; commit the new level once the window is reached.
  always_comb begin
    state_next = state;
    count_next = count;
    clean_next = clean_out;
    case (state)
      DB_IDLE: begin
        if (sync2 != clean_out) begin
          state_next = DB_COUNT;
          count_next = CNT_W'(1);
        end else begin
          count_next = CNT_W'(0);
        end
      end
      DB_COUNT: begin
        if (sync2 == clean_out) begin
          // Input bounced back before the window elapsed; drop progress.
          state_next = DB_IDLE;
          count_next = CNT_W'(0);
        end else if (count == CNT_W'(STABLE_CYCLES)) begin
          state_next = DB_IDLE;
          count_next = CNT_W'(0);
          clean_next = sync2;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      default: begin
        state_next = DB_IDLE;
        count_next = CNT_W'(0);
      end
    endcase
  end

  // FSM state, counter and debounced output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= DB_IDLE;
      count     <= CNT_W'(0);
      clean_out <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      clean_out <= clean_next;
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  // Edge pulses register in the same edge that clean_out takes its new value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= clean_next & ~clean_out;
      fall_pulse <= ~clean_next & clean_out;
    end
  end
`endif

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer top: CHANNELS independent debounce_channel instances.
// Optional feature macro: DEBOUNCE_EDGE_EN (adds rise_pulse / fall_pulse).
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = DB_STABLE_50MHZ_20MS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] clean_out
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .raw_in    (raw_in[i]),
      .clean_out (clean_out[i])
`ifdef DEBOUNCE_EDGE_EN
      ,
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
`endif
    );
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions raw board inputs (DE0-Nano push-buttons/DIP switches) into clean, synchronous levels.
- Sits directly upstream of the combinational AND-OR logic block and feeds its four inputs.
- Per channel: 2-flop synchronizer, then a stability counter. The output changes only after the input has held a new value for STABLE_CYCLES consecutive clocks.

Parameters:
- CHANNELS, 4, number of independent input channels.
- STABLE_CYCLES, 1000000, consecutive cycles a new synchronized value must hold before the output changes (20 ms at 50 MHz). Must be >= 1.
- CNT_W, clog2(STABLE_CYCLES+1), stability-counter width. Derived; not overridden.

Ports:
- clock  input  1  system clock, 50 MHz on board
- reset  input  1  asynchronous, active-high reset
- raw_in  input  CHANNELS  unsynchronized board inputs
- clean_out  output  CHANNELS  debounced levels, registered
- rise_pulse  output  CHANNELS  one-cycle pulse on clean_out 0->1 (only with DEBOUNCE_EDGE_EN)
- fall_pulse  output  CHANNELS  one-cycle pulse on clean_out 1->0 (only with DEBOUNCE_EDGE_EN)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: sync flops, counters, clean_out, rise_pulse and fall_pulse all 0. Assertion takes effect immediately; release is sampled on the next clock edge.
- Reset mid-count: counter discards progress; clean_out returns to 0.
- Synchronizer: sync1 <= raw_in; sync2 <= sync1. Only sync2 is used downstream.
- Channels are fully independent. Simultaneous transitions on several channels are each handled on their own timeline.
- Per-channel FSM, two states:
  - IDLE: counter = 0. If sync2 != clean_out, go to COUNT with counter = 1.
  - COUNT, sync2 == clean_out (bounce back): counter <= 0, go to IDLE. clean_out is unchanged.
  - COUNT, sync2 != clean_out, counter == STABLE_CYCLES: clean_out <= sync2, counter <= 0, go to IDLE.
  - COUNT, sync2 != clean_out, otherwise: counter increments.
- Latency: raw_in held stable from clock edge E0 gives clean_out updated at edge E0 + STABLE_CYCLES + 2.
- Glitches shorter than STABLE_CYCLES cycles at sync2 never reach clean_out.
- Counter never wraps. Maximum value is STABLE_CYCLES, which fits in CNT_W bits.
- STABLE_CYCLES = 1: clean_out follows sync2 with one extra cycle of delay.
- raw_in held constant after reset: clean_out never toggles.

Optional Feature:
- Macro: DEBOUNCE_EDGE_EN.
- Defined: rise_pulse and fall_pulse ports exist and are registered. Each pulses high for exactly one cycle, in the same cycle clean_out is first seen at its new value. At most one of the two is high per channel per cycle.
- Undefined: both ports and their registers are absent. clean_out behaviour is identical.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: DB_IDLE = 1'b0, DB_COUNT = 1'b1.
  - Default STABLE_CYCLES constant (DB_STABLE_50MHZ_20MS = 1000000).
  - Clog2 helper function.
- Sub-module debounce_channel: one bit, containing synchronizer, counter, FSM and optional edge registers. Instantiated CHANNELS times via generate. The top is only wiring.

Test Plan (STABLE_CYCLES = 4, CHANNELS = 4, DEBOUNCE_EDGE_EN defined):
- Reset: raw_in = 4'b1111 during reset -> clean_out = 0 and pulses = 0 while reset is high. clean_out = 4'b1111 exactly 6 edges after release; rise_pulse = 4'b1111 for one cycle in that same cycle.
- Clean step: raw_in 0->1 on channel 0 at edge E0 -> clean_out[0] = 1 at E0+6. Channels 1-3 stay 0; fall_pulse stays 0.
- Bounce: channel 2 toggles 1,0,1,0 each cycle for 3 cycles, then holds 1 -> clean_out[2] rises only 6 edges after the final stable 1. No pulse during the bounce.
- Short glitch: channel 1 at 1, drops to 0 for 3 cycles -> clean_out[1] stays 1 and fall_pulse[1] never asserts.
- Simultaneous events: ch0 falls while ch3 rises at the same edge -> both update at E0+6. fall_pulse = 4'b0001 and rise_pulse = 4'b1000 in the same cycle.
- Reset mid-count: assert reset 2 cycles into a channel-0 rise -> outputs 0 immediately. After release with raw still 1, clean_out[0] rises a full 6 edges later, with no carried-over count.
